// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data) arbiter for an asynchronous external SRAM.
// Optional feature macro SRAM_ARB_RR_EN: round-robin tie breaking (default: data port wins ties).

module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic        sram_data_oe,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        gnt_d_r;
  logic        we_r;
  logic        pick_d_s;
  logic        if_ack_r, d_ack_r, busy_r;
  logic [31:0] if_rdata_r, d_rdata_r, sram_wdata_r;
  logic [19:0] sram_addr_r;
  logic        sram_ce_n_r, sram_oe_n_r, sram_we_n_r, sram_data_oe_r;
  logic [3:0]  sram_be_n_r;
  logic        unused_addr_bits_s;

`ifdef SRAM_ARB_RR_EN
  logic        last_d_r;
`endif

  // Only word address bits [21:2] reach the SRAM.
  assign unused_addr_bits_s = ^{if_addr[31:22], if_addr[1:0], d_addr[31:22], d_addr[1:0]};

  // Grant decision for the IDLE state.
  always_comb begin
    pick_d_s = 1'b0;
    if (d_req && !if_req) begin
      pick_d_s = 1'b1;
    end else if (d_req && if_req) begin
`ifdef SRAM_ARB_RR_EN
      pick_d_s = ~last_d_r;
`else
      pick_d_s = 1'b1;
`endif
    end else begin
      pick_d_s = 1'b0;
    end
  end

  // Transfer FSM; every output is registered with the value of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      gnt_d_r        <= 1'b1;
      we_r           <= 1'b0;
      if_ack_r       <= 1'b0;
      d_ack_r        <= 1'b0;
      if_rdata_r     <= 32'd0;
      d_rdata_r      <= 32'd0;
      sram_addr_r    <= 20'd0;
      sram_wdata_r   <= 32'd0;
      sram_ce_n_r    <= 1'b1;
      sram_oe_n_r    <= 1'b1;
      sram_we_n_r    <= 1'b1;
      sram_be_n_r    <= 4'hF;
      sram_data_oe_r <= 1'b0;
      busy_r         <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_d_r       <= 1'b1;
`endif
    end else begin
      if_ack_r <= 1'b0;
      d_ack_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (if_req || d_req) begin
            state_r     <= SETUP;
            busy_r      <= 1'b1;
            gnt_d_r     <= pick_d_s;
            sram_ce_n_r <= 1'b0;
            sram_we_n_r <= 1'b1;
`ifdef SRAM_ARB_RR_EN
            last_d_r    <= pick_d_s;
`endif
            if (pick_d_s) begin
              we_r           <= d_we;
              sram_addr_r    <= d_addr[21:2];
              sram_wdata_r   <= d_wdata;
              sram_be_n_r    <= ~d_be;
              sram_oe_n_r    <= d_we;
              sram_data_oe_r <= d_we;
            end else begin
              we_r           <= 1'b0;
              sram_addr_r    <= if_addr[21:2];
              sram_be_n_r    <= 4'b0000;
              sram_oe_n_r    <= 1'b0;
              sram_data_oe_r <= 1'b0;
            end
          end
        end
        SETUP: begin
          state_r     <= ACCESS;
          cnt_r       <= 4'd0;
          sram_we_n_r <= ~we_r;
        end
        ACCESS: begin
          if (cnt_r == LAST_CNT) begin
            state_r     <= DONE;
            sram_we_n_r <= 1'b1;
            if (gnt_d_r) begin
              d_ack_r <= 1'b1;
              if (!we_r) d_rdata_r <= sram_rdata;
            end else begin
              if_ack_r   <= 1'b1;
              if_rdata_r <= sram_rdata;
            end
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          state_r        <= IDLE;
          cnt_r          <= 4'd0;
          busy_r         <= 1'b0;
          sram_ce_n_r    <= 1'b1;
          sram_oe_n_r    <= 1'b1;
          sram_we_n_r    <= 1'b1;
          sram_be_n_r    <= 4'hF;
          sram_data_oe_r <= 1'b0;
        end
        default: begin
          state_r        <= IDLE;
          cnt_r          <= 4'd0;
          busy_r         <= 1'b0;
          sram_ce_n_r    <= 1'b1;
          sram_oe_n_r    <= 1'b1;
          sram_we_n_r    <= 1'b1;
          sram_be_n_r    <= 4'hF;
          sram_data_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack       = if_ack_r;
  assign d_ack        = d_ack_r;
  assign if_rdata     = if_rdata_r;
  assign d_rdata      = d_rdata_r;
  assign sram_addr    = sram_addr_r;
  assign sram_wdata   = sram_wdata_r;
  assign sram_ce_n    = sram_ce_n_r;
  assign sram_oe_n    = sram_oe_n_r;
  assign sram_we_n    = sram_we_n_r;
  assign sram_be_n    = sram_be_n_r;
  assign sram_data_oe = sram_data_oe_r;
  assign busy         = busy_r;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, legal range 1..15: number of ACCESS cycles per SRAM transfer.
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports if_req input 1, if_addr input 32, if_ack output 1, if_rdata output 32: instruction-fetch read port.
REQ-005 SHALL have ports d_req input 1, d_we input 1, d_be input 4, d_addr input 32, d_wdata input 32, d_ack output 1, d_rdata output 32: data read/write port.
REQ-006 SHALL have ports sram_addr output 20, sram_wdata output 32, sram_rdata input 32, sram_ce_n output 1, sram_oe_n output 1, sram_we_n output 1, sram_be_n output 4, sram_data_oe output 1 (tristate enable for the external data bus).
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-008 SHALL implement a four-state FSM: IDLE, SETUP, ACCESS, DONE.
REQ-009 IDLE: if any req is high at the clock edge, grant one requester, latch its address, wdata, be and we, and go to SETUP; otherwise stay.
REQ-010 SHALL drive sram_addr = latched addr[21:2]; fetch transfers are reads with sram_be_n = 4'b0000; data transfers use sram_be_n = ~d_be.
REQ-011 SETUP (1 cycle): sram_ce_n = 0; sram_oe_n = 0 for reads; sram_we_n = 1; sram_data_oe = 1 for writes.
REQ-012 ACCESS (exactly WAIT_CYCLES cycles, 4-bit counter): control as SETUP, except sram_we_n = 0 for writes.
REQ-013 A read SHALL capture sram_rdata at the edge ending the last ACCESS cycle into the granted port's rdata register.
REQ-014 DONE (1 cycle): sram_we_n = 1, ce_n/oe_n still asserted; sram_data_oe stays 1 for writes (hold); granted port's ack = 1 for exactly this cycle; next state IDLE.
REQ-015 Request sampled at edge N SHALL give ack high in cycle N+2+WAIT_CYCLES; with WAIT_CYCLES=1, three cycles.
REQ-016 Requester SHALL keep req high until ack and drop it on the edge ending the ack cycle; req still high in the following IDLE cycle is a new request.
REQ-017 Inputs of the non-granted port SHALL be ignored until IDLE; its req waits without loss.
REQ-018 if_rdata and d_rdata SHALL hold their value until that port's next read ack; write acks SHALL leave d_rdata unchanged.
REQ-019 Outside SETUP/ACCESS/DONE: sram_ce_n = sram_oe_n = sram_we_n = 1, sram_be_n = 4'hF, sram_data_oe = 0.
REQ-020 Simultaneous if_req and d_req in IDLE SHALL be resolved per REQ-025/REQ-026.
REQ-021 sram_we_n and sram_oe_n SHALL never be low in the same cycle.

Reset
REQ-022 On rst low, asynchronously: state IDLE, counter 0, if_ack = d_ack = 0, if_rdata = d_rdata = 0, sram_addr = 0, sram_wdata = 0, sram_ce_n = sram_oe_n = sram_we_n = 1, sram_be_n = 4'hF, sram_data_oe = 0, busy = 0, last-grant pointer = data.
REQ-023 Reset mid-transfer SHALL abort it with no ack issued; in-flight write may be partial.
REQ-024 After rst release, first request SHALL be accepted at the first clock edge.

Configuration
REQ-025 With SRAM_ARB_RR_EN defined: ties go to the port not granted last; pointer updates on every grant.
REQ-026 Without SRAM_ARB_RR_EN: ties always go to the data port; no pointer state is built.

Verification
REQ-027 Fetch read, WAIT_CYCLES=1, if_addr=0x0000_0010, sram_rdata=0x2402_0005 -> sram_addr=0x00004, if_ack in 3rd cycle after grant, if_rdata=0x2402_0005.
REQ-028 Data write d_addr=0x0000_0104, d_be=4'b0011, d_wdata=0xDEAD_BEEF -> sram_be_n=4'b1100, sram_we_n low only in ACCESS cycle, sram_wdata=0xDEAD_BEEF, d_ack once, d_rdata unchanged.
REQ-029 if_req and d_req asserted together and held, RR_EN defined -> grants fetch, data, fetch; RR_EN undefined -> data first, then fetch.
REQ-030 WAIT_CYCLES=3, data read -> sram_oe_n low for 5 cycles (SETUP + 3 ACCESS + DONE), d_ack in 5th cycle after grant.
REQ-031 rst low during ACCESS of a write -> all SRAM controls inactive immediately, no ack, busy=0; next request completes normally.
